// File: rtl/axi_wr_burst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_burst_seq_pkg
// Description : Shared types for the ADC-to-AXI burst sequencer: write-side
//               FSM state encoding, helper status codes and a size helper.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_wr_burst_seq_pkg;

  // Width of the helper status bus
  localparam int c_status_w = 2;

  // Write-side FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } wr_state_t;

  // Status codes returned by the AXI-3 write helper
  typedef enum logic [1:0] {
    STAT_RDY  = 2'd0,
    STAT_WAIT = 2'd1,
    STAT_OK   = 2'd2,
    STAT_ERR  = 2'd3
  } wr_status_t;

  // AXI AxSIZE encoding for a given data-bus width in bits
  function automatic logic [2:0] f_size_code(input int bus_width);
    return 3'($clog2(bus_width / 8));
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_wr_burst_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_burst_seq_if
// Description : Enable/status handshake and burst payload between the burst
//               sequencer (master) and the AXI-3 write helper (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_wr_burst_seq_if
  import axi_wr_burst_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int BURST_LEN  = 16
) ();

  logic                            wr_enable;
  logic [ADDR_WIDTH-1:0]           wr_addr;
  logic [BURST_LEN*BUS_WIDTH-1:0]  wr_data;
  logic [3:0]                      wr_burst_len;
  logic [2:0]                      wr_burst_size;
  logic [BUS_WIDTH/8-1:0]          wr_strb;
  logic [c_status_w-1:0]           wr_status;

  modport master (
    output wr_enable, wr_addr, wr_data, wr_burst_len, wr_burst_size, wr_strb,
    input  wr_status
  );

  modport slave (
    input  wr_enable, wr_addr, wr_data, wr_burst_len, wr_burst_size, wr_strb,
    output wr_status
  );

endinterface
`default_nettype wire

// File: rtl/axi_wr_sample_pack.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_sample_pack
// Description : Packs SAMPLE_WIDTH samples into BUS_WIDTH words, LSB-first.
//               o_word/o_word_valid are combinational in the cycle the last
//               sample of a word is accepted, so the word can be banked on
//               the same edge. i_flush discards a partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_sample_pack #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BUS_WIDTH    = 64
) (
  input  wire logic                    clock,
  input  wire logic                    reset,
  input  wire logic                    i_flush,
  input  wire logic [SAMPLE_WIDTH-1:0] i_sample_data,
  input  wire logic                    i_sample_accept,
  output logic      [BUS_WIDTH-1:0]    o_word,
  output logic                         o_word_valid
);

  localparam int SPW = BUS_WIDTH / SAMPLE_WIDTH;

  generate
    if (SPW == 1) begin : g_single
      assign o_word       = i_sample_data;
      assign o_word_valid = i_sample_accept;
    end else begin : g_multi
      localparam int               CNT_W  = $clog2(SPW);
      localparam logic [CNT_W-1:0] c_last = CNT_W'(SPW - 1);

      logic [CNT_W-1:0]     r_cnt;
      logic [BUS_WIDTH-1:0] r_shift;

      // New samples enter at the top so the oldest ends up in the LSBs
      assign o_word       = {i_sample_data, r_shift[BUS_WIDTH-1:SAMPLE_WIDTH]};
      assign o_word_valid = i_sample_accept && (r_cnt == c_last);

      // Shift register and sample-in-word counter; flush drops a partial word
      always_ff @(posedge clock) begin
        if (reset || i_flush) begin
          r_cnt   <= '0;
          r_shift <= '0;
        end else if (i_sample_accept) begin
          r_shift <= o_word;
          r_cnt   <= (r_cnt == c_last) ? '0 : r_cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/axi_wr_burst_seq.sv
`default_nettype none
// ============================================================================
// Module      : axi_wr_burst_seq
// Description : Feeds the AXI-3 write helper from a continuous ADC sample
//               stream. Samples are packed into bus words, gathered into one
//               of two banks of BURST_LEN words, and each full bank is issued
//               as one burst into a circular SDRAM region. While one bank is
//               in flight the other keeps filling.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_wr_burst_seq
  import axi_wr_burst_seq_pkg::*;
#(
  parameter int                    SAMPLE_WIDTH = 16,
  parameter int                    BUS_WIDTH    = 64,
  parameter int                    BURST_LEN    = 16,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h2000_0000,
  parameter int                    RING_BYTES   = 65536
) (
  input  wire logic                    clock,
  input  wire logic                    reset,
  input  wire logic                    run,
  input  wire logic                    clear,
  input  wire logic [SAMPLE_WIDTH-1:0] sample_data,
  input  wire logic                    sample_valid,
  output logic                         sample_ready,
  axi_wr_burst_seq_if.master           wr_if,
  output logic      [31:0]             word_count,
  output logic                         overflow,
  output logic                         wr_error
);

  localparam int BANK_W = BURST_LEN * BUS_WIDTH;
  localparam int IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [IDX_W-1:0]      c_last_idx    = IDX_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] c_burst_bytes = ADDR_WIDTH'(BURST_LEN * BUS_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] c_ring_bytes  = ADDR_WIDTH'(RING_BYTES);
  localparam logic [31:0]           c_burst_words = 32'(BURST_LEN);

  // Fill side
  logic [BANK_W-1:0]     r_bank [2];
  logic                  r_fill_sel;
  logic [IDX_W-1:0]      r_widx;
  logic                  r_fill_full;
  logic                  r_ready;
  logic [BUS_WIDTH-1:0]  w_word;
  logic                  w_word_valid;
  logic                  w_accept;
  logic                  w_last_word;
  logic                  w_fill_full;
  logic                  w_swap;
  logic                  w_wr_sel;

  // Write side
  wr_state_t             r_state;
  wr_state_t             w_next_state;
  wr_status_t            w_status;
  logic                  w_wr_enable;
  logic                  r_wr_busy;
  logic                  w_wr_free;
  logic                  w_complete;
  logic [ADDR_WIDTH-1:0] r_offset;
  logic [ADDR_WIDTH-1:0] w_offset_inc;

  // Sticky flags and counter
  logic [31:0]           r_word_count;
  logic                  r_overflow;
  logic                  r_wr_error;

  assign w_status     = wr_status_t'(wr_if.wr_status);
  assign sample_ready = run && r_ready;
  assign w_accept     = sample_valid && sample_ready;

  axi_wr_sample_pack #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .BUS_WIDTH    (BUS_WIDTH)
  ) u_pack (
    .clock           (clock),
    .reset           (reset),
    .i_flush         (!run),
    .i_sample_data   (sample_data),
    .i_sample_accept (w_accept),
    .o_word          (w_word),
    .o_word_valid    (w_word_valid)
  );

  // The completing last word counts as "full" in its own cycle so an idle
  // write side can swap on the same edge, giving one-cycle issue latency.
  assign w_last_word = w_word_valid && (r_widx == c_last_idx);
  assign w_fill_full = r_fill_full || w_last_word;
  assign w_complete  = (r_state == ST_WAIT) &&
                       ((w_status == STAT_OK) || (w_status == STAT_ERR));
  assign w_wr_free   = !r_wr_busy || w_complete;
  assign w_swap      = run && w_fill_full && w_wr_free;
  assign w_wr_sel    = ~r_fill_sel;

  // Fill-bank bookkeeping: word index, full flag, ready and bank swap
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fill_sel  <= 1'b0;
      r_widx      <= '0;
      r_fill_full <= 1'b0;
      r_ready     <= 1'b0;
    end else if (!run) begin
      // Stopping discards whatever was gathered but not yet in flight
      r_widx      <= '0;
      r_fill_full <= 1'b0;
      r_ready     <= 1'b1;
    end else if (w_swap) begin
      r_fill_sel  <= ~r_fill_sel;
      r_widx      <= '0;
      r_fill_full <= 1'b0;
      r_ready     <= 1'b1;
    end else if (w_word_valid) begin
      if (w_last_word) begin
        r_widx      <= '0;
        r_fill_full <= 1'b1;
        r_ready     <= 1'b0;
      end else begin
        r_widx      <= r_widx + IDX_W'(1);
      end
    end else begin
      r_ready <= !r_fill_full;
    end
  end

  // Bank storage: completed words land at the fill bank's current index
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
    end else if (w_word_valid) begin
      r_bank[r_fill_sel][32'(r_widx) * BUS_WIDTH +: BUS_WIDTH] <= w_word;
    end
  end

  // Write-side FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Write-side FSM next state and helper enable
  always_comb begin
    w_next_state = r_state;
    w_wr_enable  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_wr_busy || w_swap) begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Drop enable in the very cycle the helper reports it has taken the burst
        w_wr_enable = (w_status != STAT_WAIT);
        if (w_status == STAT_WAIT) begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_complete) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_offset_inc = r_offset + c_burst_bytes;

  // Write-bank busy flag and ring offset; the offset advances even on error
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_busy <= 1'b0;
      r_offset  <= '0;
    end else begin
      if (w_swap) begin
        r_wr_busy <= 1'b1;
      end else if (w_complete) begin
        r_wr_busy <= 1'b0;
      end
      if (w_complete) begin
        r_offset <= (w_offset_inc == c_ring_bytes) ? '0 : w_offset_inc;
      end
    end
  end

  // Word counter and sticky flags; a same-cycle event beats clear
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_wr_error   <= 1'b0;
    end else begin
      if (w_complete && (w_status == STAT_OK)) begin
        r_word_count <= clear ? c_burst_words : r_word_count + c_burst_words;
      end else if (clear) begin
        r_word_count <= '0;
      end

      if (w_complete && (w_status == STAT_ERR)) begin
        r_wr_error <= 1'b1;
      end else if (clear) begin
        r_wr_error <= 1'b0;
      end

      if (sample_valid && !sample_ready && run) begin
        r_overflow <= 1'b1;
      end else if (clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Address is only presented while a burst is outstanding
  assign wr_if.wr_enable     = w_wr_enable;
  assign wr_if.wr_addr       = (r_state != ST_IDLE) ? (BASE_ADDR + r_offset) : '0;
  assign wr_if.wr_data       = r_bank[w_wr_sel];
  assign wr_if.wr_burst_len  = 4'(BURST_LEN - 1);
  assign wr_if.wr_burst_size = f_size_code(BUS_WIDTH);
  assign wr_if.wr_strb       = '1;

  assign word_count = r_word_count;
  assign overflow   = r_overflow;
  assign wr_error   = r_wr_error;

endmodule
`default_nettype wire
